// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce scheduler and its prescaler.
package debounce_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_TICK_DIV     = 250000;
  localparam int unsigned DEF_STABLE_TICKS = 4;

  function automatic int unsigned cnt_w(input int unsigned stable_ticks);
    return (stable_ticks < 2) ? 1 : $clog2(stable_ticks);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Pin-side bundle of the debounce scheduler; evt_clear/evt_flags exist only
// when DEBOUNCE_SCHED_EVT_LATCH_EN is defined.
interface debounce_scheduler_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              enable;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] press_pulse;
  logic [NUM_CH-1:0] release_pulse;
  logic              scan_busy;
`ifdef DEBOUNCE_SCHED_EVT_LATCH_EN
  logic [NUM_CH-1:0] evt_clear;
  logic [NUM_CH-1:0] evt_flags;

  modport master (
    output enable, raw_in, evt_clear,
    input  level_out, press_pulse, release_pulse, scan_busy, evt_flags
  );
  modport slave (
    input  enable, raw_in, evt_clear,
    output level_out, press_pulse, release_pulse, scan_busy, evt_flags
  );
`else
  modport master (
    output enable, raw_in,
    input  level_out, press_pulse, release_pulse, scan_busy
  );
  modport slave (
    input  enable, raw_in,
    output level_out, press_pulse, release_pulse, scan_busy
  );
`endif
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles;
// enable low clears and holds the count.
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // A strobe registered on the last enabled cycle is dropped if enable falls.
  assign tick = tick_q & enable;

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debouncer: one prescaled tick scans every channel through a shared
// compare/update path. Optional event latch: DEBOUNCE_SCHED_EVT_LATCH_EN.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input logic                  clock,
  input logic                  reset,
  debounce_scheduler_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_w(STABLE_TICKS);
  localparam int unsigned IDX_W = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  if (TICK_DIV < NUM_CH + 2) begin : g_bad_tick_div
    $error("debounce_scheduler: TICK_DIV must be at least NUM_CH+2");
  end
  if (STABLE_TICKS < 2 || STABLE_TICKS > 15) begin : g_bad_stable
    $error("debounce_scheduler: STABLE_TICKS must be within 2..15");
  end

  logic                         tick;
  logic [NUM_CH-1:0]            sync1_q, sync1_d;
  logic [NUM_CH-1:0]            sync_in_q, sync_in_d;
  scan_state_e                  state_q, state_d;
  logic [IDX_W-1:0]             ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            level_q, level_d;
  logic [NUM_CH-1:0]            press_q, press_d;
  logic [NUM_CH-1:0]            release_q, release_d;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (tick)
  );

  always_comb begin
    sync1_d   = bus.raw_in;
    sync_in_d = sync1_q;
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = SCAN;
          ch_idx_d = '0;
        end
      end
      SCAN: begin
        if (sync_in_q[ch_idx_q] == level_q[ch_idx_q]) begin
          cnt_d[ch_idx_q] = '0;
        end else if (cnt_q[ch_idx_q] == CNT_LAST) begin
          cnt_d[ch_idx_q]     = '0;
          level_d[ch_idx_q]   = ~level_q[ch_idx_q];
          press_d[ch_idx_q]   = ~level_q[ch_idx_q];
          release_d[ch_idx_q] = level_q[ch_idx_q];
        end else begin
          cnt_d[ch_idx_q] = cnt_q[ch_idx_q] + CNT_W'(1);
        end
        if (ch_idx_q == IDX_LAST) begin
          state_d  = IDLE;
          ch_idx_d = '0;
        end else begin
          ch_idx_d = ch_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync_in_q <= '0;
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync_in_q <= sync_in_d;
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.level_out     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.scan_busy     = (state_q == SCAN);

`ifdef DEBOUNCE_SCHED_EVT_LATCH_EN
  logic [NUM_CH-1:0] evt_flags_q, evt_flags_d;

  // Set term is OR-ed last so a coincident clear loses.
  always_comb begin
    evt_flags_d = (evt_flags_q & ~bus.evt_clear) | press_q | release_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evt_flags_q <= '0;
    end else begin
      evt_flags_q <= evt_flags_d;
    end
  end

  assign bus.evt_flags = evt_flags_q;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler (NUM_CH=4, TICK_DIV=10, STABLE_TICKS=3);
// also exercises the event latch when DEBOUNCE_SCHED_EVT_LATCH_EN is defined.
`timescale 1ns/1ps
module tb_debounce_scheduler;

  localparam int unsigned N = 4;

  logic clock = 1'b0;
  logic reset;

  debounce_scheduler_if #(.NUM_CH(N)) dif ();

  debounce_scheduler #(
    .NUM_CH       (N),
    .TICK_DIV     (10),
    .STABLE_TICKS (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned ch;
    bit          rise;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_evt(input int unsigned ch, input bit rise);
    exp_t e;
    e.ch   = ch;
    e.rise = rise;
    sb.push_back(e);
  endtask

  // Pulse monitor: pos counts cycles since scan_busy rose, so channel k's
  // pulse must appear at pos k+1.
  initial begin : monitor
    logic          prev_busy;
    int            pos;
    exp_t          e;
    logic [N-1:0]  ev, exp_p, exp_r;
    prev_busy = 1'b0;
    pos       = 0;
    forever begin
      @(negedge clock);
      if (dif.scan_busy && !prev_busy) pos = 0;
      else pos++;
      prev_busy = dif.scan_busy;
      ev = dif.press_pulse | dif.release_pulse;
      if (ev != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {24'd0, dif.press_pulse, dif.release_pulse}, 32'd0);
        end else begin
          e     = sb.pop_front();
          exp_p = e.rise ? N'(1 << e.ch) : '0;
          exp_r = e.rise ? '0 : N'(1 << e.ch);
          check("pulse_press", 32'(dif.press_pulse), 32'(exp_p));
          check("pulse_release", 32'(dif.release_pulse), 32'(exp_r));
          check("pulse_level", 32'(dif.level_out[e.ch]), 32'(e.rise));
          check("pulse_pos", 32'(pos), 32'(e.ch + 1));
        end
      end
    end
  end

  task automatic wait_scans(input int n, input string name);
    int   seen;
    int   budget;
    logic p;
    seen   = 0;
    budget = 0;
    p      = dif.scan_busy;
    while (seen < n && budget < 40 * n + 40) begin
      @(negedge clock);
      budget++;
      if (p && !dif.scan_busy) seen++;
      p = dif.scan_busy;
    end
    check(name, 32'(seen), 32'(n));
    #1;
  endtask

  task automatic cycles_to_rise(output int c);
    logic p;
    c = 0;
    p = dif.scan_busy;
    do begin
      @(negedge clock);
      c++;
      if (!p && dif.scan_busy) break;
      p = dif.scan_busy;
    end while (c < 100);
  endtask

  initial begin : stimulus
    int c;
    int busy_seen;
    reset       = 1'b1;
    dif.enable  = 1'b0;
    dif.raw_in  = '0;
`ifdef DEBOUNCE_SCHED_EVT_LATCH_EN
    dif.evt_clear = '0;
`endif
    #1;
    check("rst_level", 32'(dif.level_out), 32'd0);
    check("rst_press", 32'(dif.press_pulse), 32'd0);
    check("rst_release", 32'(dif.release_pulse), 32'd0);
    check("rst_busy", 32'(dif.scan_busy), 32'd0);
`ifdef DEBOUNCE_SCHED_EVT_LATCH_EN
    check("rst_flags", 32'(dif.evt_flags), 32'd0);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    busy_seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (dif.scan_busy) busy_seen++;
    end
    check("no_scan_before_enable", 32'(busy_seen), 32'd0);

    dif.enable = 1'b1;
    cycles_to_rise(c);
    check("first_tick_latency", 32'(c), 32'd11);
    cycles_to_rise(c);
    check("tick_period", 32'(c), 32'd10);
    wait_scans(1, "align_scan");

    // Establish level 0101, then reset in the middle of a scan.
    dif.raw_in = 4'b0101;
    expect_evt(0, 1'b1);
    expect_evt(2, 1'b1);
    wait_scans(2, "p02_scans_a");
    check("p02_not_early", 32'(sb.size()), 32'd2);
    wait_scans(1, "p02_scans_b");
    check("p02_drained", 32'(sb.size()), 32'd0);
    check("p02_level", 32'(dif.level_out), 32'b0101);

    cycles_to_rise(c);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(dif.level_out), 32'd0);
    check("async_rst_busy", 32'(dif.scan_busy), 32'd0);
    check("async_rst_pulses", 32'({dif.press_pulse, dif.release_pulse}), 32'd0);
    expect_evt(0, 1'b1);
    expect_evt(2, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cycles_to_rise(c);
    check("post_rst_tick_latency", 32'(c), 32'd11);
    wait_scans(3, "rearm_scans");
    check("rearm_drained", 32'(sb.size()), 32'd0);
    check("rearm_level", 32'(dif.level_out), 32'b0101);

    // Clean press on channel 1.
    dif.raw_in = 4'b0111;
    expect_evt(1, 1'b1);
    wait_scans(2, "p1_scans_a");
    check("p1_not_early", 32'(sb.size()), 32'd1);
    wait_scans(1, "p1_scans_b");
    check("p1_drained", 32'(sb.size()), 32'd0);
    check("p1_level", 32'(dif.level_out), 32'b0111);

    // Release channels 0 and 2.
    dif.raw_in = 4'b0010;
    expect_evt(0, 1'b0);
    expect_evt(2, 1'b0);
    wait_scans(2, "r02_scans_a");
    check("r02_not_early", 32'(sb.size()), 32'd2);
    wait_scans(1, "r02_scans_b");
    check("r02_drained", 32'(sb.size()), 32'd0);
    check("r02_level", 32'(dif.level_out), 32'b0010);

    // Two-scan glitch on channel 2 must be rejected; a three-scan hold accepted.
    dif.raw_in = 4'b0110;
    wait_scans(2, "glitch_scans_a");
    dif.raw_in = 4'b0010;
    wait_scans(4, "glitch_scans_b");
    check("glitch_level", 32'(dif.level_out), 32'b0010);
    dif.raw_in = 4'b0110;
    expect_evt(2, 1'b1);
    wait_scans(3, "hold_scans");
    check("hold_drained", 32'(sb.size()), 32'd0);
    check("hold_level", 32'(dif.level_out), 32'b0110);

    // All four channels rise together.
    dif.raw_in = 4'b0000;
    expect_evt(1, 1'b0);
    expect_evt(2, 1'b0);
    wait_scans(3, "clr_scans");
    check("clr_level", 32'(dif.level_out), 32'd0);
    dif.raw_in = 4'b1111;
    for (int unsigned i = 0; i < N; i++) expect_evt(i, 1'b1);
    wait_scans(2, "sim_scans_a");
    check("sim_not_early", 32'(sb.size()), 32'd4);
    wait_scans(1, "sim_scans_b");
    check("sim_drained", 32'(sb.size()), 32'd0);
    check("sim_level", 32'(dif.level_out), 32'b1111);

    // Drop enable mid-scan; count for channel 0 must survive the pause.
    dif.raw_in = 4'b1110;
    expect_evt(0, 1'b0);
    wait_scans(1, "gate_scan1");
    cycles_to_rise(c);
    dif.enable = 1'b0;
    c = 0;
    while (dif.scan_busy && c < 20) begin
      @(negedge clock);
      c++;
    end
    check("gate_scan_completes", 32'(c), 32'd4);
    busy_seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (dif.scan_busy) busy_seen++;
    end
    check("gate_no_scan", 32'(busy_seen), 32'd0);
    check("gate_pending", 32'(sb.size()), 32'd1);
    check("gate_level_held", 32'(dif.level_out), 32'b1111);
    dif.enable = 1'b1;
    cycles_to_rise(c);
    check("gate_reenable_latency", 32'(c), 32'd11);
    wait_scans(1, "gate_scan3");
    check("gate_drained", 32'(sb.size()), 32'd0);
    check("gate_level", 32'(dif.level_out), 32'b1110);

`ifdef DEBOUNCE_SCHED_EVT_LATCH_EN
    dif.raw_in = 4'b0110;
    expect_evt(3, 1'b0);
    wait_scans(3, "evt_pre_scans");
    dif.evt_clear = '1;
    @(negedge clock);
    dif.evt_clear = '0;
    @(negedge clock);
    check("evt_all_cleared", 32'(dif.evt_flags), 32'd0);
    dif.raw_in = 4'b1110;
    expect_evt(3, 1'b1);
    wait_scans(3, "evt_press_scans");
    check("evt_press_flag", 32'(dif.evt_flags), 32'b1000);
    repeat (5) @(negedge clock);
    check("evt_flag_sticky", 32'(dif.evt_flags), 32'b1000);
    dif.evt_clear = 4'b1000;
    @(negedge clock);
    dif.evt_clear = '0;
    @(negedge clock);
    check("evt_flag_cleared", 32'(dif.evt_flags), 32'd0);
    dif.raw_in = 4'b0110;
    expect_evt(3, 1'b0);
    dif.evt_clear = 4'b1000;
    c = 0;
    while (!dif.release_pulse[3] && c < 100) begin
      @(negedge clock);
      c++;
    end
    check("evt_release_seen", 32'(dif.release_pulse[3]), 32'd1);
    @(negedge clock);
    check("evt_set_wins", 32'(dif.evt_flags), 32'b1000);
    dif.evt_clear = '0;
    @(negedge clock);
    check("evt_set_holds", 32'(dif.evt_flags), 32'b1000);
    wait_scans(1, "evt_tail_scan");
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
